// File: rtl/codec_record_capture.sv
// Captures AC97 record frames (mono-mixed) into an on-chip buffer after a level
// trigger, then replays the buffer as a sample/strobe stream for the playback path.
module codec_record_capture #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] THRESHOLD  = 16'd1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_button,
  input  logic                  play_button,
  input  logic                  new_frame,
  input  logic [15:0]           record_left,
  input  logic [15:0]           record_right,
  output logic [15:0]           sample_out,
  output logic                  new_sample_generated,
  output logic                  recording,
  output logic                  playing,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   sample_count
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    RECORD = 3'd2,
    STORED = 3'd3,
    PLAY   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;

  logic [15:0]           mem [DEPTH];
  logic [15:0]           rd_data_q;
  logic                  rd_valid_q;
  logic [15:0]           sample_out_q;
  logic                  pulse_q;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Mono mix: 17-bit sum then arithmetic halve, so no overflow is possible.
  logic [16:0] mix_sum;
  logic [15:0] mono;
  logic [16:0] mono_ext;
  logic [16:0] mono_abs;
  logic        trigger;

  always_comb begin
    mix_sum  = {record_left[15], record_left} + {record_right[15], record_right};
    mono     = 16'(mix_sum >> 1);
    mono_ext = {mono[15], mono};
    mono_abs = mono[15] ? (17'd0 - mono_ext) : mono_ext;
    trigger  = (mono_abs >= {1'b0, THRESHOLD});
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    wr_en    = 1'b0;
    wr_addr  = count_q[ADDR_WIDTH-1:0];
    rd_en    = 1'b0;
    rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];

    // record_button is tested first in every state so it wins over play_button.
    case (state_q)
      IDLE: begin
        if (record_button) begin
          state_d = ARMED;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      ARMED: begin
        if (record_button) begin
          state_d = IDLE;
        end else if (new_frame && trigger) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = CNT_ONE;
          state_d = RECORD;
        end
      end
      RECORD: begin
        if (record_button) begin
          state_d = STORED;
        end else if (new_frame) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_ONE;
          if (count_q + CNT_ONE == FULL_COUNT) begin
            full_d  = 1'b1;
            state_d = STORED;
          end
        end
      end
      STORED: begin
        if (record_button) begin
          state_d = ARMED;
          count_d = '0;
          full_d  = 1'b0;
        end else if (play_button && (count_q != '0)) begin
          state_d  = PLAY;
          rd_ptr_d = '0;
        end
      end
      PLAY: begin
        if (record_button) begin
          state_d = ARMED;
          count_d = '0;
          full_d  = 1'b0;
        end else if (play_button) begin
          state_d = STORED;
        end else if (new_frame) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + CNT_ONE;
          if (rd_ptr_q + CNT_ONE == count_q) begin
            state_d = STORED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // Buffer RAM: one write port, one registered read port, no reset on contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= mono;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Output stage adds the second cycle of latency; pulses track the read valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q   <= 1'b0;
      sample_out_q <= '0;
      pulse_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      pulse_q    <= rd_valid_q;
      if (rd_valid_q) begin
        sample_out_q <= rd_data_q;
      end
    end
  end

  assign sample_out           = sample_out_q;
  assign new_sample_generated = pulse_q;
  assign recording            = (state_q == ARMED) || (state_q == RECORD);
  assign playing              = (state_q == PLAY);
  assign full                 = full_q;
  assign sample_count         = count_q;

endmodule

// File: tb/tb_codec_record_capture.sv
// Directed bench for codec_record_capture with a 16-entry buffer.
module tb_codec_record_capture;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          record_button;
  logic          play_button;
  logic          new_frame;
  logic [15:0]   record_left;
  logic [15:0]   record_right;
  logic [15:0]   sample_out;
  logic          new_sample_generated;
  logic          recording;
  logic          playing;
  logic          full;
  logic [AW:0]   sample_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            pulse_cnt = 0;
  logic [15:0]   got_q[$];

  codec_record_capture #(.ADDR_WIDTH(AW), .THRESHOLD(16'd1024)) dut (
    .clk                  (clk),
    .reset                (reset),
    .record_button        (record_button),
    .play_button          (play_button),
    .new_frame            (new_frame),
    .record_left          (record_left),
    .record_right         (record_right),
    .sample_out           (sample_out),
    .new_sample_generated (new_sample_generated),
    .recording            (recording),
    .playing              (playing),
    .full                 (full),
    .sample_count         (sample_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_sample_generated) begin
      pulse_cnt++;
      got_q.push_back(sample_out);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    record_left  = l;
    record_right = r;
    new_frame    = 1'b1;
    cycle();
    new_frame    = 1'b0;
  endtask

  task automatic press_rec();
    record_button = 1'b1;
    cycle();
    record_button = 1'b0;
  endtask

  task automatic press_play();
    play_button = 1'b1;
    cycle();
    play_button = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; record_button = 1'b0; play_button = 1'b0; new_frame = 1'b0;
    record_left = '0; record_right = '0;
    cycle(); cycle();
    reset = 1'b0;
    n_cmp++;
    if ({sample_out, new_sample_generated, recording, playing, full, sample_count} !== 25'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", {sample_out, new_sample_generated, recording, playing, full, sample_count});
    end
    $display("reset done");
  endtask

  task automatic test_armed_trigger();
    press_rec();
    frame(16'd100, 16'd100);
    frame(16'd100, 16'd100);
    n_cmp++;
    if ({recording, playing, sample_count} !== {1'b1, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL armed_small got rec=%b play=%b cnt=%0d want 1 0 0", recording, playing, sample_count);
    end
    frame(16'd2000, 16'd0);
    n_cmp++;
    if (sample_count !== 5'd0) begin
      n_bad++; $display("FAIL armed_1000 got cnt=%0d want 0", sample_count);
    end
    frame(-16'sd1500, -16'sd1500);
    n_cmp++;
    if ({recording, sample_count} !== {1'b1, 5'd1}) begin
      n_bad++; $display("FAIL trigger got rec=%b cnt=%0d want 1 1", recording, sample_count);
    end
    frame(16'd5, 16'd5);
    n_cmp++;
    if (sample_count !== 5'd2) begin
      n_bad++; $display("FAIL record_small got cnt=%0d want 2", sample_count);
    end
    press_rec();
    n_cmp++;
    if ({recording, full, sample_count} !== {1'b0, 1'b0, 5'd2}) begin
      n_bad++; $display("FAIL stop_stored got rec=%b full=%b cnt=%0d want 0 0 2", recording, full, sample_count);
    end
    $display("armed/trigger done, count=%0d", sample_count);
  endtask

  task automatic test_full_play();
    press_rec();
    n_cmp++;
    if ({recording, full, sample_count} !== {1'b1, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL rearm got rec=%b full=%b cnt=%0d want 1 0 0", recording, full, sample_count);
    end
    frame(16'd1023, 16'd1023);
    n_cmp++;
    if (sample_count !== 5'd0) begin
      n_bad++; $display("FAIL below_thresh got cnt=%0d want 0", sample_count);
    end
    for (int k = 0; k < 16; k++) frame(16'(1024 + k), 16'(1024 + k));
    n_cmp++;
    if ({full, recording, sample_count} !== {1'b1, 1'b0, 5'd16}) begin
      n_bad++; $display("FAIL fill got full=%b rec=%b cnt=%0d want 1 0 16", full, recording, sample_count);
    end
    frame(16'd7, 16'd7);
    frame(16'd7, 16'd7);
    n_cmp++;
    if ({full, sample_count} !== {1'b1, 5'd16}) begin
      n_bad++; $display("FAIL extra_frames got full=%b cnt=%0d want 1 16", full, sample_count);
    end
    pulse_cnt = 0;
    got_q.delete();
    press_play();
    n_cmp++;
    if (playing !== 1'b1) begin
      n_bad++; $display("FAIL play_start got playing=%b want 1", playing);
    end
    for (int k = 0; k < 16; k++) begin
      new_frame = 1'b1;
      cycle();
      new_frame = 1'b0;
      n_cmp++;
      if (new_sample_generated !== 1'b0) begin
        n_bad++; $display("FAIL play_t1[%0d] got pulse=%b want 0", k, new_sample_generated);
      end
      if (k == 15) begin
        n_cmp++;
        if (playing !== 1'b0) begin
          n_bad++; $display("FAIL play_end_state got playing=%b want 0", playing);
        end
      end
      cycle();
      n_cmp++;
      if ({new_sample_generated, sample_out} !== {1'b1, 16'(1024 + k)}) begin
        n_bad++; $display("FAIL play_t2[%0d] got pulse=%b data=%0d want 1 %0d", k, new_sample_generated, sample_out, 1024 + k);
      end
      $display("play frame %0d sample_out=%0d", k, sample_out);
      cycle();
      n_cmp++;
      if (new_sample_generated !== 1'b0) begin
        n_bad++; $display("FAIL play_t3[%0d] got pulse=%b want 0", k, new_sample_generated);
      end
      cycle();
    end
    frame(16'd0, 16'd0);
    cycle(); cycle();
    n_cmp++;
    if ({playing, pulse_cnt} !== {1'b0, 32'd16}) begin
      n_bad++; $display("FAIL play_total got playing=%b pulses=%0d want 0 16", playing, pulse_cnt);
    end
  endtask

  task automatic test_early_stop();
    logic [15:0] exp_es [5];
    exp_es = '{16'd2000, -16'sd10, -16'sd20, -16'sd30, -16'sd40};
    press_rec();
    n_cmp++;
    if ({full, sample_count} !== {1'b0, 5'd0}) begin
      n_bad++; $display("FAIL es_rearm got full=%b cnt=%0d want 0 0", full, sample_count);
    end
    frame(16'd3000, 16'd1001);
    for (int k = 1; k < 5; k++) frame(16'(-10 * k), 16'(-10 * k));
    press_rec();
    n_cmp++;
    if ({recording, full, sample_count} !== {1'b0, 1'b0, 5'd5}) begin
      n_bad++; $display("FAIL es_stop got rec=%b full=%b cnt=%0d want 0 0 5", recording, full, sample_count);
    end
    pulse_cnt = 0;
    got_q.delete();
    press_play();
    new_frame = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    new_frame = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    n_cmp++;
    if ({playing, pulse_cnt} !== {1'b0, 32'd5}) begin
      n_bad++; $display("FAIL es_pulses got playing=%b pulses=%0d want 0 5", playing, pulse_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= got_q.size()) begin
        n_bad++; $display("FAIL es_data[%0d] got none want %0d", k, $signed(exp_es[k]));
      end else if (got_q[k] !== exp_es[k]) begin
        n_bad++; $display("FAIL es_data[%0d] got %0d want %0d", k, $signed(got_q[k]), $signed(exp_es[k]));
      end
    end
    n_cmp++;
    if (sample_out !== exp_es[4]) begin
      n_bad++; $display("FAIL es_hold got %0d want -40", $signed(sample_out));
    end
    $display("early stop playback pulses=%0d", pulse_cnt);
  endtask

  task automatic test_simultaneous();
    pulse_cnt = 0;
    record_button = 1'b1;
    play_button   = 1'b1;
    cycle();
    record_button = 1'b0;
    play_button   = 1'b0;
    n_cmp++;
    if ({recording, playing, sample_count} !== {1'b1, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL simul got rec=%b play=%b cnt=%0d want 1 0 0", recording, playing, sample_count);
    end
    cycle(); cycle(); cycle();
    n_cmp++;
    if (pulse_cnt !== 0) begin
      n_bad++; $display("FAIL simul_pulses got %0d want 0", pulse_cnt);
    end
    press_rec();
    n_cmp++;
    if (recording !== 1'b0) begin
      n_bad++; $display("FAIL cancel got rec=%b want 0", recording);
    end
    press_play();
    frame(16'd2000, 16'd2000);
    n_cmp++;
    if ({recording, playing, sample_count} !== {1'b0, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL idle_play got rec=%b play=%b cnt=%0d want 0 0 0", recording, playing, sample_count);
    end
    $display("simultaneous/idle checks done");
  endtask

  task automatic test_reset_mid_play();
    press_rec();
    frame(16'h8000, 16'h8000);
    n_cmp++;
    if (sample_count !== 5'd1) begin
      n_bad++; $display("FAIL min_trigger got cnt=%0d want 1", sample_count);
    end
    frame(16'd2000, 16'd2000);
    press_rec();
    press_play();
    new_frame = 1'b1;
    cycle();
    new_frame = 1'b0;
    cycle();
    n_cmp++;
    if ({new_sample_generated, sample_out} !== {1'b1, 16'h8000}) begin
      n_bad++; $display("FAIL min_replay got pulse=%b data=%h want 1 8000", new_sample_generated, sample_out);
    end
    cycle();
    pulse_cnt = 0;
    reset     = 1'b1;
    new_frame = 1'b1;
    cycle();
    reset     = 1'b0;
    new_frame = 1'b0;
    n_cmp++;
    if ({sample_out, new_sample_generated, recording, playing, full, sample_count} !== 25'd0) begin
      n_bad++; $display("FAIL mid_reset got %h want 0", {sample_out, new_sample_generated, recording, playing, full, sample_count});
    end
    cycle(); cycle();
    n_cmp++;
    if ({pulse_cnt, sample_out} !== {32'd0, 16'd0}) begin
      n_bad++; $display("FAIL mid_reset_pending got pulses=%0d data=%h want 0 0", pulse_cnt, sample_out);
    end
    $display("reset mid-play done");
  endtask

  initial begin
    test_reset();
    test_armed_trigger();
    test_full_play();
    test_early_stop();
    test_simultaneous();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
